// File: rtl/req_hold_arbiter_if.sv
// req_hold_arbiter_if: request/grant bundle between requesters and the hold arbiter.
// Latency: none, wires only.
// Backpressure: requesters hold req high to keep a grant; the arbiter drives everything else.
interface req_hold_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int CNT_W = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout;
  logic             short_err;

  // Requester side: drives requests, observes grant status.
  modport master (
    output req,
    input  gnt, gnt_id, busy, hold_cnt, timeout, short_err
  );

  // Arbiter side: samples requests, drives grant status.
  modport slave (
    input  req,
    output gnt, gnt_id, busy, hold_cnt, timeout, short_err
  );
endinterface

// File: rtl/req_hold_arbiter.sv
// req_hold_arbiter: registered round-robin arbiter; owner keeps grant while req high, pre-empted after MAX_HOLD.
// Latency: grant 1 cycle after sampled request; minimum 2-cycle gap (RELEASE + IDLE) between grants.
// Backpressure: lone owner holds indefinitely; optional REQ_HOLD_CHECK_EN adds short_err and assertions.
module req_hold_arbiter #(
  parameter int N_REQ    = 2,
  parameter int MIN_HOLD = 2,
  parameter int MAX_HOLD = 5,
  parameter int CNT_W    = 4,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input logic              clk,
  input logic              rst_n,
  req_hold_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
  localparam logic [ID_W-1:0]  LAST_RST   = ID_W'(N_REQ - 1);

  // Parameter sanity, caught at elaboration.
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("req_hold_arbiter: N_REQ must be 2..8");
  end
  if (MIN_HOLD < 1 || MIN_HOLD > MAX_HOLD) begin : g_bad_min
    $error("req_hold_arbiter: MIN_HOLD must be 1..MAX_HOLD");
  end
  if ((2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cnt
    $error("req_hold_arbiter: CNT_W too narrow for MAX_HOLD");
  end

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic             pick_vld;
  logic [ID_W-1:0]  pick_id;
  logic             own_req;
  logic             other_req;

  // Owner is gnt_id while in GRANT; others are every request bit not currently granted.
  assign own_req   = bus.req[gnt_id_q];
  assign other_req = |(bus.req & ~gnt_q);

  // Round-robin pick: first set request searching upward from last_id+1, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = last_q;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!pick_vld && bus.req[ID_W'((int'(last_q) + i) % N_REQ)]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'((int'(last_q) + i) % N_REQ);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: drop or expired-with-contention releases, RELEASE always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = GRANT;
      GRANT:   if (!own_req || (hold_q == MAX_HOLD_C && other_req)) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values; every output is registered so nothing follows req combinationally.
  always_comb begin
    gnt_d     = '0;
    gnt_id_d  = gnt_id_q;
    last_d    = last_q;
    hold_d    = '0;
    busy_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d[pick_id] = 1'b1;
          gnt_id_d       = pick_id;
          busy_d         = 1'b1;
          hold_d         = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!own_req) begin
          // Voluntary release; short-hold flagging is handled separately.
        end else if (hold_q == MAX_HOLD_C && other_req) begin
          timeout_d = 1'b1;
        end else begin
          gnt_d  = gnt_q;
          busy_d = 1'b1;
          hold_d = (hold_q == MAX_HOLD_C) ? hold_q : hold_q + 1'b1;
        end
      end
      RELEASE: begin
        // Remember the outgoing owner so the next search starts after it.
        last_d = gnt_id_q;
      end
      default: ;
    endcase
  end

  // Output registers; async reset drops the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      gnt_id_q  <= LAST_RST;
      last_q    <= LAST_RST;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.gnt_id   = gnt_id_q;
  assign bus.busy     = busy_q;
  assign bus.hold_cnt = hold_q;
  assign bus.timeout  = timeout_q;

`ifdef REQ_HOLD_CHECK_EN
  localparam logic [CNT_W-1:0] MIN_HOLD_C = CNT_W'(MIN_HOLD);

  logic short_q;

  // Pulse in the RELEASE cycle when the owner dropped before MIN_HOLD cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_q <= 1'b0;
    end else begin
      short_q <= (state_q == GRANT) && !own_req && (hold_q < MIN_HOLD_C);
    end
  end

  assign bus.short_err = short_q;

  a_min_hold: assert property (@(posedge clk) disable iff (!rst_n)
    ((state_q == GRANT) && !own_req) |-> (hold_q >= MIN_HOLD_C))
    else $error("req_hold_arbiter: granted request dropped before MIN_HOLD");

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q))
    else $error("req_hold_arbiter: gnt not one-hot or zero");

  a_timeout_pending: assert property (@(posedge clk) disable iff (!rst_n)
    timeout_q |-> (|($past(bus.req) & ~$past(gnt_q))))
    else $error("req_hold_arbiter: timeout without another pending request");
`else
  assign bus.short_err = 1'b0;
`endif

endmodule

// File: doc/req_hold_arbiter.md
Name: req_hold_arbiter

Overview:
- Registered round-robin arbiter that shares one resource between N_REQ level-sensitive requesters.
- A requester keeps its grant while its request stays high, up to a maximum hold window.
- Once the window expires and another requester is waiting, the grant is pre-empted.
- Sits in front of any shared resource whose requesters follow the hold-N-ticks request protocol. Also reports grant hold length and protocol violations for assertion-based checking.

Parameters:
N_REQ, 2, number of requesters (2..8)
MIN_HOLD, 2, minimum cycles a granted request must stay high (1..MAX_HOLD)
MAX_HOLD, 5, cycles after which a held grant may be pre-empted
CNT_W, 4, hold counter width; must satisfy 2**CNT_W > MAX_HOLD
ID_W, $clog2(N_REQ), grant index width

Ports:
clk  input  1  clock, posedge active
rst_n  input  1  asynchronous active-low reset
req  input  N_REQ  level request per requester
gnt  output  N_REQ  one-hot grant, registered
gnt_id  output  ID_W  index of current/last owner
busy  output  1  high while in GRANT state
hold_cnt  output  CNT_W  cycles current grant has been held
timeout  output  1  one-cycle pulse on forced pre-emption
short_err  output  1  one-cycle pulse on early request drop (see optional feature)

Behaviour:
- Reset (async assert, sync release):
  - gnt=0, gnt_id=N_REQ-1, busy=0, hold_cnt=0, timeout=0, short_err=0.
  - State IDLE; internal last_id=N_REQ-1, so requester 0 wins the first tie.
  - Reset mid-grant drops gnt immediately.
- FSM states IDLE, GRANT, RELEASE.
- IDLE:
  - If any req bit is sampled high, pick the first set bit searching from last_id+1 modulo N_REQ.
  - Next cycle: gnt[winner]=1, gnt_id=winner, busy=1, hold_cnt=1, state GRANT.
  - Grant latency is 1 cycle from sampled request. No request: stay IDLE, all outputs 0 except gnt_id.
- GRANT, evaluated at each posedge on sampled req, in priority order:
  1. req[owner]=0: go RELEASE. If hold_cnt<MIN_HOLD, short_err pulses in the RELEASE cycle.
  2. req[owner]=1, hold_cnt==MAX_HOLD, and any other req bit high: go RELEASE; timeout pulses in the RELEASE cycle.
  3. Otherwise stay in GRANT. hold_cnt increments, saturating at MAX_HOLD, so a lone requester holds indefinitely with no timeout.
  - Request changes from non-owners never affect the current grant.
- RELEASE:
  - Exactly one cycle with gnt=0, busy=0, hold_cnt=0. gnt_id keeps the last owner; last_id<=owner.
  - Next state is IDLE, which re-arbitrates. Minimum gap between grants is therefore 2 cycles (RELEASE + IDLE decision).
- Invariants:
  - gnt is always zero or one-hot.
  - timeout and short_err are never high together.
  - gnt is never asserted in the same cycle as a sampled request edge; all outputs are registered.
- The owner re-requesting immediately after release is arbitrated normally; round-robin gives another pending requester priority.

Optional Feature:
- Macro: REQ_HOLD_CHECK_EN.
- Defined:
  - short_err is generated as above.
  - Embedded concurrent assertions are compiled in:
    - a granted request holds for MIN_HOLD cycles;
    - gnt is one-hot or zero;
    - timeout implies another request is pending.
  - Each assertion reports via $error on failure.
- Undefined: short_err is tied to 0, the assertions are absent, and all other behaviour is identical.

Test Plan:
1. Reset: rst_n=0 while gnt[0]=1 with hold_cnt=3 -> gnt=0, busy=0, hold_cnt=0 immediately. After release, req=2'b11 -> gnt=2'b01 one cycle later.
2. Single request: req0 high for 4 cycles, req1=0 -> gnt[0] high 4 cycles with hold_cnt 1,2,3,4, then one RELEASE cycle; timeout=0, short_err=0.
3. Tie/rotation: req=2'b11 held continuously, defaults -> gnt0 for 5 cycles, timeout pulse, RELEASE, IDLE, then gnt1 for 5 cycles, timeout; grants alternate 0,1,0.
4. Saturation: req0 alone high for 12 cycles -> gnt[0] high 12 cycles, hold_cnt saturates at 5, timeout never asserts.
5. Pre-emption: req0 high for 10 cycles, req1 rises at grant cycle 2 -> timeout in cycle 6, gnt[0] falls, gnt[1] rises 2 cycles later.
6. Short hold: req1 granted, drops after 1 cycle -> short_err=1 for 1 cycle with REQ_HOLD_CHECK_EN defined, stays 0 without it; hold-length assertion fires only when the macro is defined.
